// File: rtl/alu_arbiter.sv
// Round-robin share of one external combinational ALU between two requesters,
// each with a one-entry response buffer that can drain and refill in the same cycle.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int FUNC_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [FUNC_W-1:0] req0_func,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [FUNC_W-1:0] req1_func,
  output logic [DATA_W-1:0] alu_bits_a,
  output logic [DATA_W-1:0] alu_bits_b,
  output logic [FUNC_W-1:0] alu_func,
  input  logic [DATA_W-1:0] alu_out_bits,
  input  logic              alu_compare_val,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp0_bits,
  output logic              rsp0_cmp,
  output logic [DATA_W-1:0] rsp1_bits,
  output logic              rsp1_cmp
);

  typedef enum logic {BUF_EMPTY = 1'b0, BUF_FULL = 1'b1} buf_state_e;

  logic              prio_q, prio_d;
  logic [1:0]        eligible;
  logic [1:0]        grant;
  logic [DATA_W-1:0] bits_w [2];
  logic [1:0]        cmp_w;

  // A requester may issue only if its buffer is empty or being drained this cycle.
  assign eligible  = req_valid & (~rsp_valid | rsp_ready);
  assign req_ready = grant;

  always_comb begin
    grant = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    prio_d = prio_q;
    if (grant[0]) begin
      prio_d = 1'b1;
    end else if (grant[1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  always_comb begin
    alu_bits_a = '0;
    alu_bits_b = '0;
    alu_func   = '0;
    if (grant[0]) begin
      alu_bits_a = req0_a;
      alu_bits_b = req0_b;
      alu_func   = req0_func;
    end else if (grant[1]) begin
      alu_bits_a = req1_a;
      alu_bits_b = req1_b;
      alu_func   = req1_func;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    buf_state_e        state_q, state_d;
    logic [DATA_W-1:0] bits_q, bits_d;
    logic              cmp_q, cmp_d;

    // A grant implies the buffer is empty or draining, so it always (re)loads.
    always_comb begin
      state_d = state_q;
      bits_d  = bits_q;
      cmp_d   = cmp_q;
      if (grant[gi]) begin
        state_d = BUF_FULL;
        bits_d  = alu_out_bits;
        cmp_d   = alu_compare_val;
      end else if (state_q == BUF_FULL && rsp_ready[gi]) begin
        state_d = BUF_EMPTY;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= BUF_EMPTY;
        bits_q  <= '0;
        cmp_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        bits_q  <= bits_d;
        cmp_q   <= cmp_d;
      end
    end

    assign rsp_valid[gi] = (state_q == BUF_FULL);
    assign bits_w[gi]    = bits_q;
    assign cmp_w[gi]     = cmp_q;
  end

  assign rsp0_bits = bits_w[0];
  assign rsp1_bits = bits_w[1];
  assign rsp0_cmp  = cmp_w[0];
  assign rsp1_cmp  = cmp_w[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a small ALU model closes the loop, and each step
// checks the combinational grant/ALU mux, then the registered response buffers.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int FW = 10;

  localparam logic [FW-1:0] F_ADD = 10'h000;
  localparam logic [FW-1:0] F_SLL = 10'h001;
  localparam logic [FW-1:0] F_BEQ = 10'h002;
  localparam logic [FW-1:0] F_XOR = 10'h004;
  localparam logic [FW-1:0] F_SRA = 10'h105;

  logic          clk;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [FW-1:0] req0_func, req1_func;
  logic [DW-1:0] alu_bits_a, alu_bits_b;
  logic [FW-1:0] alu_func;
  logic [DW-1:0] alu_out_bits;
  logic          alu_compare_val;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [DW-1:0] rsp0_bits, rsp1_bits;
  logic          rsp0_cmp, rsp1_cmp;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.DATA_W(DW), .FUNC_W(FW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
    .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
    .alu_bits_a(alu_bits_a), .alu_bits_b(alu_bits_b), .alu_func(alu_func),
    .alu_out_bits(alu_out_bits), .alu_compare_val(alu_compare_val),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp0_bits(rsp0_bits), .rsp0_cmp(rsp0_cmp),
    .rsp1_bits(rsp1_bits), .rsp1_cmp(rsp1_cmp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: compare flag is equality for BEQ, inequality otherwise.
  always_comb begin
    alu_out_bits = '0;
    case (alu_func[2:0])
      3'd0: alu_out_bits = alu_bits_a + alu_bits_b;
      3'd1: alu_out_bits = alu_bits_a << alu_bits_b[4:0];
      3'd2: alu_out_bits = alu_bits_a - alu_bits_b;
      3'd4: alu_out_bits = alu_bits_a ^ alu_bits_b;
      3'd5: alu_out_bits = alu_func[8] ? DW'($signed(alu_bits_a) >>> alu_bits_b[4:0])
                                       : (alu_bits_a >> alu_bits_b[4:0]);
      default: alu_out_bits = alu_bits_a + alu_bits_b;
    endcase
    alu_compare_val = (alu_func[2:0] == 3'd2) ? (alu_bits_a == alu_bits_b)
                                              : (alu_bits_a != alu_bits_b);
  end

  typedef struct {
    string         name;
    logic          rst;
    logic [1:0]    rv;
    logic [1:0]    rr;
    logic [DW-1:0] a0, b0;
    logic [FW-1:0] f0;
    logic [DW-1:0] a1, b1;
    logic [FW-1:0] f1;
    logic [1:0]    exp_ready;
    logic [1:0]    exp_valid;
    logic [DW-1:0] exp_bits0;
    logic          exp_cmp0;
    logic [DW-1:0] exp_bits1;
    logic          exp_cmp1;
  } vec_t;

  function automatic vec_t mk(
    input string nm, input logic r, input logic [1:0] rv, input logic [1:0] rr,
    input logic [DW-1:0] a0, input logic [DW-1:0] b0, input logic [FW-1:0] f0,
    input logic [DW-1:0] a1, input logic [DW-1:0] b1, input logic [FW-1:0] f1,
    input logic [1:0] er, input logic [1:0] ev,
    input logic [DW-1:0] eb0, input logic ec0, input logic [DW-1:0] eb1, input logic ec1);
    vec_t v;
    v.name = nm; v.rst = r; v.rv = rv; v.rr = rr;
    v.a0 = a0; v.b0 = b0; v.f0 = f0; v.a1 = a1; v.b1 = b1; v.f1 = f1;
    v.exp_ready = er; v.exp_valid = ev;
    v.exp_bits0 = eb0; v.exp_cmp0 = ec0; v.exp_bits1 = eb1; v.exp_cmp1 = ec1;
    return v;
  endfunction

  task automatic chk(input string step, input string what,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", step, what, act, exp);
    end
  endtask

  // Drive after the falling edge, check combinational outputs, then registered ones after the rising edge.
  task automatic run_step(input vec_t v);
    logic [DW-1:0] ea, eb;
    logic [FW-1:0] ef;
    rst = v.rst; req_valid = v.rv; rsp_ready = v.rr;
    req0_a = v.a0; req0_b = v.b0; req0_func = v.f0;
    req1_a = v.a1; req1_b = v.b1; req1_func = v.f1;
    #1;
    ea = '0; eb = '0; ef = '0;
    if (v.exp_ready == 2'b01) begin
      ea = v.a0; eb = v.b0; ef = v.f0;
    end else if (v.exp_ready == 2'b10) begin
      ea = v.a1; eb = v.b1; ef = v.f1;
    end
    chk(v.name, "req_ready", 64'(req_ready), 64'(v.exp_ready));
    chk(v.name, "alu_a", 64'(alu_bits_a), 64'(ea));
    chk(v.name, "alu_b", 64'(alu_bits_b), 64'(eb));
    chk(v.name, "alu_func", 64'(alu_func), 64'(ef));
    @(posedge clk);
    #1;
    chk(v.name, "rsp_valid", 64'(rsp_valid), 64'(v.exp_valid));
    chk(v.name, "rsp0_bits", 64'(rsp0_bits), 64'(v.exp_bits0));
    chk(v.name, "rsp0_cmp", 64'(rsp0_cmp), 64'(v.exp_cmp0));
    chk(v.name, "rsp1_bits", 64'(rsp1_bits), 64'(v.exp_bits1));
    chk(v.name, "rsp1_cmp", 64'(rsp1_cmp), 64'(v.exp_cmp1));
    $display("step %-10s rst=%b req_valid=%b rsp_ready=%b req_ready=%b rsp_valid=%b rsp0=%h/%b rsp1=%h/%b",
             v.name, v.rst, v.rv, v.rr, req_ready, rsp_valid, rsp0_bits, rsp0_cmp, rsp1_bits, rsp1_cmp);
    @(negedge clk);
  endtask

  vec_t vecs [18];

  initial begin
    vecs[0]  = mk("reset",     1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    vecs[1]  = mk("idle",      0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0);
    vecs[2]  = mk("single",    0, 2'b01, 2'b00, 5, 3, F_ADD, 0, 0, 0, 2'b01, 2'b01, 8, 1, 0, 0);
    vecs[3]  = mk("hold0",     0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 8, 1, 0, 0);
    vecs[4]  = mk("drain0",    0, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 8, 1, 0, 0);
    vecs[5]  = mk("req1_beq",  0, 2'b10, 2'b00, 0, 0, 0, 7, 7, F_BEQ, 2'b10, 2'b10, 8, 1, 0, 1);
    vecs[6]  = mk("drain1",    0, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 8, 1, 0, 1);
    vecs[7]  = mk("cont_a",    0, 2'b11, 2'b11, 1, 1, F_ADD, 32'hF0, 32'h0F, F_XOR, 2'b01, 2'b01, 2, 0, 0, 1);
    vecs[8]  = mk("cont_b",    0, 2'b11, 2'b11, 1, 1, F_ADD, 32'hF0, 32'h0F, F_XOR, 2'b10, 2'b10, 2, 0, 32'hFF, 1);
    vecs[9]  = mk("cont_c",    0, 2'b11, 2'b11, 1, 1, F_ADD, 32'hF0, 32'h0F, F_XOR, 2'b01, 2'b01, 2, 0, 32'hFF, 1);
    vecs[10] = mk("cont_d",    0, 2'b11, 2'b11, 1, 1, F_ADD, 32'hF0, 32'h0F, F_XOR, 2'b10, 2'b10, 2, 0, 32'hFF, 1);
    vecs[11] = mk("drain_all", 0, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2, 0, 32'hFF, 1);
    vecs[12] = mk("bp_load1",  0, 2'b10, 2'b00, 0, 0, 0, 7, 7, F_BEQ, 2'b10, 2'b10, 2, 0, 0, 1);
    vecs[13] = mk("bp_0a",     0, 2'b11, 2'b01, 2, 3, F_ADD, 7, 7, F_BEQ, 2'b01, 2'b11, 5, 1, 0, 1);
    vecs[14] = mk("bp_0b",     0, 2'b11, 2'b01, 10, 20, F_ADD, 7, 7, F_BEQ, 2'b01, 2'b11, 30, 1, 0, 1);
    vecs[15] = mk("bp_0c",     0, 2'b11, 2'b01, 32'h80000000, 4, F_SRA, 7, 7, F_BEQ, 2'b01, 2'b11, 32'hF8000000, 1, 0, 1);
    vecs[16] = mk("refill",    0, 2'b01, 2'b01, 1, 4, F_SLL, 0, 0, 0, 2'b01, 2'b11, 32'h10, 1, 0, 1);
    vecs[17] = mk("release",   0, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h10, 1, 0, 1);

    for (int i = 0; i < 18; i++) begin
      run_step(vecs[i]);
    end

    // Reset while both buffers are full and both requests pending; prio is 1 going in.
    run_step(mk("rm_fill1",  0, 2'b10, 2'b00, 0, 0, 0, 32'hAA, 32'h55, F_XOR, 2'b10, 2'b10, 32'h10, 1, 32'hFF, 1));
    run_step(mk("rm_fill0",  0, 2'b01, 2'b00, 9, 9, F_ADD, 32'hAA, 32'h55, F_XOR, 2'b01, 2'b11, 18, 0, 32'hFF, 1));
    run_step(mk("rm_rst",    1, 2'b11, 2'b11, 9, 9, F_ADD, 32'hAA, 32'h55, F_XOR, 2'b10, 2'b00, 0, 0, 0, 0));
    run_step(mk("rm_first",  0, 2'b11, 2'b00, 9, 9, F_ADD, 32'hAA, 32'h55, F_XOR, 2'b01, 2'b01, 18, 0, 0, 0));
    run_step(mk("rm_idle",   0, 2'b00, 2'b11, 9, 9, F_ADD, 32'hAA, 32'h55, F_XOR, 2'b00, 2'b00, 18, 0, 0, 0));
    run_step(mk("rm_next",   0, 2'b11, 2'b11, 9, 9, F_ADD, 32'hAA, 32'h55, F_XOR, 2'b10, 2'b10, 18, 0, 32'hFF, 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters (req 0: execute stage, req 1: branch/address unit) using round-robin arbitration and valid/ready handshakes. Per cycle it grants at most one request, steers that requester's operands and func onto the ALU, and captures the ALU result and compare flag into that requester's one-entry response buffer. It sits between the issue logic and the ALU; the ALU itself is instantiated outside this block.

## Interface
- DATA_W, 32, operand/result width
- FUNC_W, 10, ALU func width (func[2:0] selects op/compare, func[8] arithmetic shift)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid[1:0]  in  2  request valid per requester
- req_ready[1:0]  out  2  request accepted this cycle (combinational)
- req0_a, req0_b / req1_a, req1_b  in  DATA_W each  operands
- req0_func / req1_func  in  FUNC_W each  ALU function
- alu_bits_a, alu_bits_b  out  DATA_W  to ALU
- alu_func  out  FUNC_W  to ALU
- alu_out_bits  in  DATA_W  ALU result
- alu_compare_val  in  1  ALU compare flag
- rsp_valid[1:0]  out  2  response buffer full
- rsp_ready[1:0]  in  2  requester consumes response
- rsp0_bits / rsp1_bits  out  DATA_W  buffered result
- rsp0_cmp / rsp1_cmp  out  1  buffered compare flag

## Operation
- Per requester i: eligible_i = req_valid[i] & (~rsp_valid[i] | rsp_ready[i]).
- Arbitration: both eligible -> grant requester indicated by prio; exactly one eligible -> grant it; none -> no grant.
- prio: 1-bit register; on any grant to requester g, prio <= ~g. Unchanged on no-grant cycles (including single-eligible grants? no: always updated on grant).
- req_ready[i] = grant_i; at most one bit set. Handshake completes when req_valid[i] & req_ready[i].
- ALU mux: grant 0 -> req0 operands/func; grant 1 -> req1; no grant -> alu_bits_a/b = 0, alu_func = 0.
- Response buffer i states EMPTY/FULL:
  - EMPTY + grant_i -> FULL, load rsp_bits/cmp from ALU.
  - FULL + rsp_ready[i] + grant_i -> FULL, reload (drain and refill same cycle).
  - FULL + rsp_ready[i] + no grant_i -> EMPTY, data held.
  - FULL + ~rsp_ready[i] -> FULL, data held, requester i ineligible.
- rsp_ready[i] while rsp_valid[i]=0 is ignored.
- Requester inputs must stay stable while req_valid high and not accepted; block does not check.
- Compare flag captured regardless of op; consumer interprets.

## Timing
- Reset (clk edge with rst=1): rsp_valid=00, rsp0/1_bits=0, rsp0/1_cmp=0, prio=0. req_ready and ALU outputs combinational; req_ready=00 while rsp_valid=00 and req_valid=00.
- rst dominates: request accepted in same cycle as rst is discarded; buffered responses lost.
- Latency: request accepted cycle N -> rsp_valid high at cycle N+1 with result.
- Throughput: one op per cycle total; each requester sustains one op/cycle when rsp_ready held high and other idle.
- Both continuously requesting with rsp_ready high: grants alternate 0,1,0,1,...
- No combinational path from rsp_ready to rsp_valid; rsp_ready -> req_ready path is combinational.

## Test plan
- Single op: after reset, req0 a=5, b=3, func=ADD -> req_ready=01 same cycle; next cycle rsp_valid[0]=1, rsp0_bits=8, rsp0_cmp=1 (not equal).
- Contention: both valid for 4 cycles, rsp_ready=11, req0 ADD 1+1, req1 XOR F0^0F -> grants 0,1,0,1; rsp0_bits=2, rsp1_bits=000000FF; prio ends 0.
- Backpressure: req1 accepted (SUB path via compare, a=b=7, func BEQ) -> rsp1_cmp=1; hold rsp_ready[1]=0 with req1_valid=1 for 3 cycles -> req_ready[1]=0, data stable; req0 still granted every cycle.
- Drain-and-refill: rsp_valid[0]=1, rsp_ready[0]=1, new req0 SLL a=1, b=4 same cycle -> accepted; next cycle rsp0_bits=0x10, rsp_valid[0] stays 1.
- Reset mid-operation: rsp_valid=11, both requests pending, assert rst one cycle -> next cycle rsp_valid=00, bits=0, prio=0; first grant after reset with both valid goes to req0.
- Idle: req_valid=00 -> req_ready=00, alu_bits_a/b=0, alu_func=0, prio unchanged.
